dbpu: RTL

Dynamic branch prediction unit for the IFU stage: predicts conditional branches with a table of 2-bit saturating counters trained by the EXU, and predicts JAL/JALR targets, with returns served from a return address stack (RAS). Prediction is combinational in the fetch cycle. Counter and RAS state is sequential. Mispredictions are still detected and recovered in the EXU.

---
 rtl/bpu_pkg.sv | 49 ++++
 rtl/bpu_ras.sv | 66 ++++++
 rtl/dbpu.sv | 127 ++++++++++++
 3 files changed

// File: rtl/bpu_pkg.sv
// Shared types, constants and helpers for the dynamic branch prediction unit.
// Holds the opcode values, the 2-bit counter encoding and the ITCM window.
package bpu_pkg;

  localparam int INST_DATA_WIDTH = 32;
  localparam int INST_ADDR_WIDTH = 32;
  localparam int REG_DATA_WIDTH  = 32;

  localparam logic [INST_ADDR_WIDTH-1:0] ITCM_BASE_ADDR = 32'h8000_0000;
  localparam logic [INST_ADDR_WIDTH-1:0] ITCM_SIZE      = 32'h0001_0000;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_ctr_t;

  function automatic logic is_link_reg(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  // Widened by one bit so the window end cannot wrap.
  function automatic logic in_itcm(input logic [INST_ADDR_WIDTH-1:0] addr);
    logic [INST_ADDR_WIDTH:0] a;
    logic [INST_ADDR_WIDTH:0] lo;
    logic [INST_ADDR_WIDTH:0] hi;
    a  = {1'b0, addr};
    lo = {1'b0, ITCM_BASE_ADDR};
    hi = lo + {1'b0, ITCM_SIZE};
    return (a >= lo) && (a < hi);
  endfunction

  function automatic bht_ctr_t ctr_next(input bht_ctr_t ctr, input logic taken);
    bht_ctr_t nxt;
    nxt = ctr;
    if (taken && (ctr != ST)) begin
      nxt = bht_ctr_t'(ctr + 2'd1);
    end else if (!taken && (ctr != SNT)) begin
      nxt = bht_ctr_t'(ctr - 2'd1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bpu_ras.sv
// Return address stack: circular storage, pointer to the next free slot,
// count saturating at DEPTH so the oldest entry is overwritten when full.
module bpu_ras
  import bpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = INST_ADDR_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic [WIDTH-1:0] top_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d, top_idx, wr_idx;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_en;
  logic             full;

  assign top_idx = ptr_q - 1'b1;
  assign top_o   = stack_q[top_idx];
  assign empty_o = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(DEPTH));

  // Push together with a pop of a live entry rewrites the top in place.
  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (flush_i) begin
      cnt_d = '0;
    end else if (push_i && pop_i && !empty_o) begin
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (push_i) begin
      wr_en = 1'b1;
      ptr_d = ptr_q + 1'b1;
      if (!full) cnt_d = cnt_q + 1'b1;
    end else if (pop_i && !empty_o) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      if (wr_en) stack_q[wr_idx] <= push_data_i;
    end
  end

endmodule

// File: rtl/dbpu.sv
// Dynamic branch prediction unit: 2-bit counter table for conditional branches,
// JAL/JALR target prediction; the return address stack is built when BPU_RAS_EN is defined.
module dbpu
  import bpu_pkg::*;
#(
  parameter int BHT_ENTRIES = 64,
  parameter int RAS_DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [INST_DATA_WIDTH-1:0] inst_i,
  input  logic                       inst_valid_i,
  input  logic [INST_ADDR_WIDTH-1:0] pc_i,
  input  logic                       any_stall_i,
  output logic [4:0]                 gpr_raddr_o,
  input  logic [REG_DATA_WIDTH-1:0]  gpr_rdata_i,
  input  logic                       upd_valid_i,
  input  logic [INST_ADDR_WIDTH-1:0] upd_pc_i,
  input  logic                       upd_taken_i,
  input  logic                       flush_i,
  output logic                       branch_taken_o,
  output logic [INST_ADDR_WIDTH-1:0] branch_addr_o,
  output logic                       is_pred_branch_o,
  output logic                       is_pred_jalr_o,
  output logic                       is_ras_pred_o
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [6:0]                 opcode;
  logic [4:0]                 rs1;
  logic                       is_br, is_jal, is_jalr;
  logic [IDX_W-1:0]           pred_idx, upd_idx;
  bht_ctr_t                   bht_q [BHT_ENTRIES];
  bht_ctr_t                   pred_ctr, upd_ctr_d;
  logic [INST_ADDR_WIDTH-1:0] imm_b, imm_j, imm_i;
  logic [INST_ADDR_WIDTH-1:0] pc_plus4, jalr_gpr_tgt, ras_top;
  logic                       pred_taken, ras_hit;
  logic                       unused_bits;

  assign opcode      = inst_i[6:0];
  assign rs1         = inst_i[19:15];
  assign gpr_raddr_o = rs1;

  assign is_br   = inst_valid_i && (opcode == OPC_BRANCH);
  assign is_jal  = inst_valid_i && (opcode == OPC_JAL);
  assign is_jalr = inst_valid_i && (opcode == OPC_JALR);

  assign imm_b = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_j = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};

  assign pc_plus4     = pc_i + 32'd4;
  assign jalr_gpr_tgt = (gpr_rdata_i + imm_i) & ~32'd1;

  assign pred_idx  = pc_i[IDX_W+1:2];
  assign upd_idx   = upd_pc_i[IDX_W+1:2];
  assign pred_ctr  = bht_q[pred_idx];
  assign upd_ctr_d = ctr_next(bht_q[upd_idx], upd_taken_i);

  assign unused_bits = ^{inst_i[14:12], upd_pc_i[1:0], upd_pc_i[INST_ADDR_WIDTH-1:IDX_W+2]};

  always_comb begin
    pred_taken    = 1'b0;
    branch_addr_o = pc_plus4;
    if (is_br) begin
      pred_taken = pred_ctr[1];
      if (pred_ctr[1]) branch_addr_o = pc_i + imm_b;
    end else if (is_jal) begin
      pred_taken    = 1'b1;
      branch_addr_o = pc_i + imm_j;
    end else if (is_jalr) begin
      pred_taken    = 1'b1;
      branch_addr_o = ras_hit ? ras_top : jalr_gpr_tgt;
    end
  end

  assign branch_taken_o   = pred_taken && !any_stall_i && !rst && in_itcm(branch_addr_o);
  assign is_pred_branch_o = is_br && pred_ctr[1];
  assign is_pred_jalr_o   = is_jalr;

  // Prediction reads the table combinationally, so a same-index update lands after the read.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= WT;
    end else if (upd_valid_i) begin
      bht_q[upd_idx] <= upd_ctr_d;
    end
  end

`ifdef BPU_RAS_EN
  logic [4:0] rd;
  logic       rd_link, rs1_link, ras_push, ras_pop, ras_commit, ras_empty;

  assign rd         = inst_i[11:7];
  assign rd_link    = is_link_reg(rd);
  assign rs1_link   = is_link_reg(rs1);
  assign ras_push   = (is_jal || is_jalr) && rd_link;
  assign ras_pop    = is_jalr && rs1_link && (!rd_link || (rd != rs1));
  assign ras_commit = inst_valid_i && !any_stall_i && !flush_i;
  assign ras_hit    = ras_pop && !ras_empty;

  assign is_ras_pred_o = ras_hit && !rst;

  bpu_ras #(
    .DEPTH(RAS_DEPTH),
    .WIDTH(INST_ADDR_WIDTH)
  ) u_ras (
    .clk         (clk),
    .rst         (rst),
    .push_i      (ras_push && ras_commit),
    .pop_i       (ras_pop && ras_commit),
    .flush_i     (flush_i),
    .push_data_i (pc_plus4),
    .top_o       (ras_top),
    .empty_o     (ras_empty)
  );
`else
  logic unused_ras;

  assign ras_hit       = 1'b0;
  assign ras_top       = '0;
  assign is_ras_pred_o = 1'b0;
  assign unused_ras    = ^{flush_i, RAS_DEPTH[0]};
`endif

endmodule
